encoder4x2_seq: RTL and testbench

//  Clocked 4-to-2 priority encoder; the encode-side counterpart of the team's 2-to-4 decoder.

---
 rtl/encoder4x2_seq.sv | 83 ++++++++
 tb/tb_encoder4x2_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/encoder4x2_seq.sv
// Clocked 4-to-2 encoder: request lines accumulate in a pending register and drain one
// code per handshake through a 1-entry output slice. Define ENC_RR_EN for round-robin selection.
module encoder4x2_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic             ready,
  output logic             valid,
  output logic             y1,
  output logic             y0,
  output logic             idle,
  output logic [CNT_W-1:0] cnt
);
  localparam int NUM_REQ = 4;

  logic [NUM_REQ-1:0] d_vec;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] load_mask;
  logic [1:0]         sel;
  logic [1:0]         code;
  logic               load;

  assign d_vec     = {d3, d2, d1, d0};
  assign load      = (pend != '0) && (!valid || ready);
  assign load_mask = load ? (NUM_REQ'(1) << sel) : '0;

`ifdef ENC_RR_EN
  logic [1:0] rr_ptr;

  // Scan downward from distance 4 so the nearest set bit after rr_ptr wins.
  always_comb begin
    sel = 2'd0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (pend[2'(rr_ptr + 2'(i))]) sel = 2'(rr_ptr + 2'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= 2'd3;
    else if (load) rr_ptr <= sel;
  end
`else
  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend[i]) sel = 2'(i);
    end
  end
`endif

  // New requests are OR'd in after the clear so a same-cycle set is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~load_mask) | d_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      code  <= 2'd0;
    end else if (load) begin
      valid <= 1'b1;
      code  <= sel;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (valid && ready) cnt <= cnt + 1'b1;
  end

  assign y1   = code[1];
  assign y0   = code[0];
  assign idle = (pend == '0) && !valid;

endmodule

// File: tb/tb_encoder4x2_seq.sv
// Directed bench for encoder4x2_seq; a second instance with CNT_W=2 checks counter wrap.
module tb_encoder4x2_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d0 = 1'b0, d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic       ready = 1'b0;
  logic       valid, y1, y0, idle;
  logic [7:0] cnt;
  logic       valid2, y1_2, y0_2, idle2;
  logic [1:0] cnt2;
  int         checks = 0;
  int         passed = 0;

  encoder4x2_seq dut (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
    .valid(valid), .y1(y1), .y0(y0), .idle(idle), .cnt(cnt)
  );

  encoder4x2_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .ready(ready),
    .valid(valid2), .y1(y1_2), .y0(y0_2), .idle(idle2), .cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle; inputs change and outputs are read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_d(4'b0000);
    ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_d(4'b1111);
    ready = 1'b1;
    step(); step();
    checks++; if (valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid); else passed++;
    checks++; if ({y1, y0} !== 2'b00) $display("FAIL rst_y got %b exp 00", {y1, y0}); else passed++;
    checks++; if (cnt !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", cnt); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL rst_idle got %b exp 1", idle); else passed++;
    rst_n = 1'b1;
    set_d(4'b0000);
    step(); step();
    checks++; if ({idle, valid} !== 2'b10) $display("FAIL rst_release_idle got idle=%b valid=%b exp idle=1 valid=0", idle, valid); else passed++;
  endtask

  task automatic test_single_pulse();
    do_reset();
    ready = 1'b1;
    set_d(4'b0100);
    step();
    checks++; if ({idle, valid} !== 2'b00) $display("FAIL pulse_pend got idle=%b valid=%b exp idle=0 valid=0", idle, valid); else passed++;
    set_d(4'b0000);
    step();
    checks++; if ({valid, y1, y0} !== 3'b110) $display("FAIL pulse_code got %b exp 110", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b010) $display("FAIL pulse_drain got %b exp 010", {valid, y1, y0}); else passed++;
    checks++; if (cnt !== 8'd1) $display("FAIL pulse_cnt got %0d exp 1", cnt); else passed++;
  endtask

  task automatic test_priority();
    do_reset();
    ready = 1'b1;
    set_d(4'b1001);
    step();
    set_d(4'b0000);
    step();
    checks++; if ({valid, y1, y0} !== 3'b111) $display("FAIL prio_first got %b exp 111", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b100) $display("FAIL prio_second got %b exp 100", {valid, y1, y0}); else passed++;
    step();
    checks++; if (cnt !== 8'd2) $display("FAIL prio_cnt got %0d exp 2", cnt); else passed++;
    checks++; if ({idle, valid} !== 2'b10) $display("FAIL prio_idle got idle=%b valid=%b exp idle=1 valid=0", idle, valid); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    set_d(4'b1000); step();
    set_d(4'b0010); step();
    checks++; if ({valid, y1, y0} !== 3'b111) $display("FAIL bp_load got %b exp 111", {valid, y1, y0}); else passed++;
    set_d(4'b0001); step();
    set_d(4'b0000); step();
    checks++; if ({valid, y1, y0} !== 3'b111) $display("FAIL bp_hold got %b exp 111", {valid, y1, y0}); else passed++;
    checks++; if (cnt !== 8'd0) $display("FAIL bp_cnt_hold got %0d exp 0", cnt); else passed++;
    ready = 1'b1;
    step();
    checks++; if ({valid, y1, y0} !== 3'b101) $display("FAIL bp_second got %b exp 101", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b100) $display("FAIL bp_third got %b exp 100", {valid, y1, y0}); else passed++;
    step();
    checks++; if (cnt !== 8'd3) $display("FAIL bp_cnt got %0d exp 3", cnt); else passed++;
    checks++; if ({idle, valid} !== 2'b10) $display("FAIL bp_idle got idle=%b valid=%b exp idle=1 valid=0", idle, valid); else passed++;
  endtask

  task automatic test_cnt_wrap_and_async_reset();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    ready = 1'b1;
    set_d(4'b0010);
    step(); step();
    checks++; if ({valid2, y1_2, y0_2, cnt2} !== 5'b10100) $display("FAIL wrap_first got %b exp 10100", {valid2, y1_2, y0_2, cnt2}); else passed++;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (cnt2 !== exp_seq[k]) $display("FAIL wrap_cnt2[%0d] got %0d exp %0d", k, cnt2, exp_seq[k]); else passed++;
    end
    checks++; if (cnt !== 8'd5) $display("FAIL wrap_cnt8 got %0d exp 5", cnt); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({valid, idle, cnt} !== {1'b0, 1'b1, 8'd0}) $display("FAIL async_rst got valid=%b idle=%b cnt=%0d exp valid=0 idle=1 cnt=0", valid, idle, cnt); else passed++;
    checks++; if ({valid2, idle2} !== 2'b01) $display("FAIL async_rst2 got valid=%b idle=%b exp valid=0 idle=1", valid2, idle2); else passed++;
    step();
    set_d(4'b0000);
    rst_n = 1'b1;
    step(); step();
    checks++; if ({idle, valid} !== 2'b10) $display("FAIL rst_discard got idle=%b valid=%b exp idle=1 valid=0", idle, valid); else passed++;
    // 8-bit counter: 256 handshakes bring it back to zero.
    set_d(4'b0010);
    step(); step();
    for (int k = 0; k < 255; k++) step();
    checks++; if (cnt !== 8'd255) $display("FAIL cnt8_max got %0d exp 255", cnt); else passed++;
    step();
    checks++; if (cnt !== 8'd0) $display("FAIL cnt8_wrap got %0d exp 0", cnt); else passed++;
    set_d(4'b0000);
  endtask

  task automatic test_selection_policy();
    logic [1:0] exp_code [4];
`ifdef ENC_RR_EN
    exp_code = '{2'b00, 2'b11, 2'b00, 2'b11};
`else
    exp_code = '{2'b11, 2'b11, 2'b11, 2'b11};
`endif
    do_reset();
    ready = 1'b1;
    set_d(4'b1001);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if ({valid, y1, y0} !== {1'b1, exp_code[k]}) $display("FAIL policy[%0d] got %b exp %b", k, {valid, y1, y0}, {1'b1, exp_code[k]}); else passed++;
    end
    set_d(4'b0000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1;
    set_d(4'b1111);
    step();
    set_d(4'b0000);
    step();
    checks++; if ({valid, y1, y0} !== 3'b111) $display("FAIL b2b_0 got %b exp 111", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b110) $display("FAIL b2b_1 got %b exp 110", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b101) $display("FAIL b2b_2 got %b exp 101", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({valid, y1, y0} !== 3'b100) $display("FAIL b2b_3 got %b exp 100", {valid, y1, y0}); else passed++;
    step();
    checks++; if ({idle, valid, cnt} !== {2'b10, 8'd4}) $display("FAIL b2b_end got idle=%b valid=%b cnt=%0d exp idle=1 valid=0 cnt=4", idle, valid, cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_priority();
    test_backpressure();
    test_cnt_wrap_and_async_reset();
    test_selection_policy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
